// File: rtl/mux8_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin select arbiter.
package mux8_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping 7 -> 0.
module rr_pick8
    import mux8_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic [SEL_W-1:0]   win_o,
    output logic               any_o
);

    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0]   off;

    // Rotating the doubled vector puts requester ptr_i at bit 0, so the lowest set bit is the winner offset.
    always_comb begin
        rot = NUM_REQ'({req_i, req_i} >> ptr_i);
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
    end

    assign win_o = ptr_i + off;
    assign any_o = |req_i;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner of a shared 8:1 word select with bounded bursts and a valid/ready downstream port.
module mux8_rr_arbiter
    import mux8_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         REQ,
    input  logic [NUM_REQ*WIDTH-1:0]   DATA_IN,
    output logic [NUM_REQ-1:0]         GRANT,
    output logic [SEL_W-1:0]           SELECT,
    output logic                       ENABLE,
    output logic [WIDTH-1:0]           DATA_OUT,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic                       BUSY
);

    // Downstream handshake: a beat transfers on any cycle where OUT_VALID and OUT_READY are both high;
    // OUT_VALID never depends on OUT_READY, and GRANT pulses to the owner on exactly that cycle.

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [3:0]       beat_q, beat_d;
    logic [SEL_W-1:0] pick_win;
    logic             pick_any;
    logic             owner_req;
    logic             last_beat;

    rr_pick8 u_pick (
        .req_i (REQ),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .any_o (pick_any)
    );

    assign owner_req = REQ[sel_q];
    assign last_beat = (beat_q == 4'(MAX_BURST - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_win;
                    beat_d  = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                // Release on withdrawal or on the final beat of the burst; the pointer moves past the owner.
                if (!owner_req) begin
                    ptr_d   = sel_q + 3'd1;
                    state_d = IDLE;
                end else if (OUT_READY) begin
                    beat_d = beat_q + 4'd1;
                    if (last_beat) begin
                        ptr_d   = sel_q + 3'd1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        GRANT     = '0;
        SELECT    = '0;
        ENABLE    = 1'b0;
        DATA_OUT  = '0;
        OUT_VALID = 1'b0;
        BUSY      = 1'b0;
        if (!RST && state_q == XFER) begin
            SELECT    = sel_q;
            ENABLE    = 1'b1;
            BUSY      = 1'b1;
            OUT_VALID = owner_req;
            DATA_OUT  = DATA_IN[sel_q*WIDTH +: WIDTH];
            if (owner_req && OUT_READY) GRANT = NUM_REQ'(1) << sel_q;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: burst, backpressure, withdrawal and reset cases on MAX_BURST=4, fairness on MAX_BURST=1.
module tb_mux8_rr_arbiter;

    localparam int W     = 32;
    localparam int EXP_W = 8 + 3 + W;

    logic         clk;
    logic         rst;
    logic [7:0]   req;
    logic [7:0]   req1;
    logic [8*W-1:0] data_in;
    logic         out_ready;

    logic [7:0]   grant,  grant1;
    logic [2:0]   sel,    sel1;
    logic         en,     en1;
    logic [W-1:0] dout,   dout1;
    logic         vld,    vld1;
    logic         busy,   busy1;

    int n_checks = 0;
    int n_fail   = 0;
    int grant_cnt = 0;

    logic [EXP_W-1:0] exp_q[$];

    mux8_rr_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut (
        .CLK(clk), .RST(rst), .REQ(req), .DATA_IN(data_in),
        .GRANT(grant), .SELECT(sel), .ENABLE(en), .DATA_OUT(dout),
        .OUT_VALID(vld), .OUT_READY(out_ready), .BUSY(busy)
    );

    mux8_rr_arbiter #(.WIDTH(W), .MAX_BURST(1)) dut1 (
        .CLK(clk), .RST(rst), .REQ(req1), .DATA_IN(data_in),
        .GRANT(grant1), .SELECT(sel1), .ENABLE(en1), .DATA_OUT(dout1),
        .OUT_VALID(vld1), .OUT_READY(out_ready), .BUSY(busy1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push_beat(input int idx);
        logic [7:0] g;
        g = 8'd1 << idx;
        exp_q.push_back({g, 3'(idx), data_in[idx*W +: W]});
    endtask

    // scoreboard: every accepted beat of the MAX_BURST=4 instance must match the next expected record
    always @(negedge clk) begin
        if (grant != 8'h00) begin
            grant_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_grant", grant, 64'h0);
            end else begin
                logic [EXP_W-1:0] e;
                e = exp_q.pop_front();
                check("beat_grant",  grant, e[EXP_W-1 -: 8]);
                check("beat_select", sel,   e[W +: 3]);
                check("beat_data",   dout,  e[W-1:0]);
                check("beat_valid",  vld,   1'b1);
            end
        end
    end

    initial begin
        int g0;
        for (int i = 0; i < 8; i++) data_in[i*W +: W] = 32'hA5A5_0000 + i;
        rst = 1'b1;
        req = 8'hFF;
        req1 = 8'h00;
        out_ready = 1'b0;

        // reset with every requester active
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_select", sel, 0);
        check("rst_enable", en, 0);
        check("rst_data", dout, 0);
        check("rst_valid", vld, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle_enable", en, 0);
        check("post_rst_idle_busy", busy, 0);
        @(negedge clk);
        check("post_rst_select", sel, 0);
        check("post_rst_enable", en, 1);
        check("post_rst_valid", vld, 1);
        check("post_rst_no_grant", grant, 0);
        @(posedge clk); #1 req = 8'h00;
        do_reset();

        // single burst of four beats from requester 2, bubble, then re-grant
        req = 8'h04;
        out_ready = 1'b1;
        for (int b = 0; b < 5; b++) push_beat(2);
        @(negedge clk);
        check("burst_arb_idle", en, 0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            check("burst_enable", en, 1);
        end
        @(negedge clk);
        check("burst_bubble_enable", en, 0);
        check("burst_bubble_data", dout, 0);
        check("burst_bubble_grant", grant, 0);
        @(negedge clk);
        check("regrant_select", sel, 2);
        check("regrant_enable", en, 1);
        @(posedge clk); #1 req = 8'h00;
        @(negedge clk);
        check("burst_queue_empty", exp_q.size(), 0);
        do_reset();

        // backpressure mid-burst on requester 3
        g0 = grant_cnt;
        req = 8'h08;
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) push_beat(3);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("bp_valid", vld, 1);
            check("bp_select", sel, 3);
            check("bp_data", dout, 32'hA5A5_0003);
            check("bp_grant", grant, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1 req = 8'h00;
        @(negedge clk);
        check("bp_release_enable", en, 0);
        check("bp_grant_pulses", grant_cnt - g0, 4);
        do_reset();

        // owner 5 withdraws before any beat is accepted
        req = 8'h20;
        out_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 req = 8'h21;
        @(negedge clk);
        check("wd_owner_select", sel, 5);
        check("wd_owner_valid", vld, 1);
        check("wd_owner_no_grant", grant, 0);
        @(posedge clk); #1 req = 8'h01; out_ready = 1'b1;
        @(negedge clk);
        check("wd_drop_valid", vld, 0);
        check("wd_drop_grant", grant, 0);
        @(posedge clk); #1 req = 8'h21;
        push_beat(0);
        @(negedge clk);
        check("wd_idle_enable", en, 0);
        @(negedge clk);
        check("wd_next_winner", sel, 0);
        @(posedge clk); #1 req = 8'h00;
        @(negedge clk);
        do_reset();

        // reset after two of four beats
        req = 8'h81;
        out_ready = 1'b1;
        push_beat(0);
        push_beat(0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_enable", en, 0);
        check("mid_rst_valid", vld, 0);
        @(posedge clk); #1 rst = 1'b0;
        push_beat(0);
        @(negedge clk);
        check("mid_rst_idle", en, 0);
        @(negedge clk);
        check("mid_rst_winner", sel, 0);
        @(posedge clk); #1 req = 8'h00;
        @(negedge clk);
        do_reset();

        // fairness with single-beat bursts on the second instance
        req1 = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            logic [7:0] eg;
            eg = 8'd1 << (k % 8);
            @(negedge clk);
            check("fair_bubble", en1, 0);
            @(negedge clk);
            check("fair_grant", grant1, eg);
            check("fair_select", sel1, k % 8);
        end
        @(posedge clk); #1 req1 = 8'h00;
        repeat (2) @(negedge clk);

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
